pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080, is the exception redirect target (used only with PC_EXC_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 STALL  input  1  hold the current PC while in VALID state.
REQ-006 BRANCH  input  1  taken-branch redirect request.
REQ-007 BRANCH_TARGET  input  32  branch destination.
REQ-008 JUMP  input  1  jump redirect request.
REQ-009 JUMP_TARGET  input  32  jump destination.
REQ-010 IMEM_ACK  input  1  instruction memory has accepted or returned the fetch at IMEM_ADDR.
REQ-011 IMEM_REQ  output  1  fetch request to instruction memory.
REQ-012 IMEM_ADDR  output  32  fetch address; always equals PC.
REQ-013 PC  output  32  current instruction address; feeds the ALU source-A select.
REQ-014 PC_PLUS4  output  32  combinational PC + 4, modulo 2^32.
REQ-015 PC_VALID  output  1  the instruction at PC is fetched and current.
REQ-016 EXC  input  1  exception request (present only with PC_EXC_EN).
REQ-017 EPC  output  32  PC of the excepting instruction (present only with PC_EXC_EN).

Function
REQ-018 The block SHALL implement three states: IDLE, FETCH and VALID.
REQ-019 IDLE SHALL go to FETCH unconditionally on the next cycle; in IDLE, IMEM_REQ=0, PC_VALID=0, and redirects and IMEM_ACK are ignored.
REQ-020 FETCH: IMEM_REQ=1, PC_VALID=0, and IMEM_ADDR SHALL stay stable until IMEM_ACK is sampled high.
REQ-021 FETCH with IMEM_ACK=1 and no pending redirect SHALL go to VALID on the next cycle.
REQ-022 FETCH with IMEM_ACK=1 and a pending redirect SHALL discard the returned fetch, load PC with the pending target, clear the pending flag, and remain in FETCH.
REQ-023 A redirect asserted in FETCH SHALL be latched into a pending-target register; a later redirect overwrites the earlier one.
REQ-024 When several redirects are asserted in the same cycle, priority SHALL be EXC > JUMP > BRANCH.
REQ-025 VALID: PC_VALID=1 and IMEM_REQ=0.
REQ-026 VALID with any redirect SHALL load PC with the redirect target and go to FETCH; the redirect SHALL override STALL.
REQ-027 VALID with STALL=1 and no redirect SHALL hold PC and remain in VALID.
REQ-028 VALID with STALL=0 and no redirect SHALL load PC with PC+4 and go to FETCH.
REQ-029 PC+4 SHALL wrap: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-030 Bits [1:0] of BRANCH_TARGET and JUMP_TARGET SHALL be forced to 0 when the target is loaded; PC[1:0] is always 0.
REQ-031 IMEM_ACK in IDLE or VALID SHALL be ignored.

Reset
REQ-032 When reset=1 at a clock edge: PC=RESET_VECTOR, state=IDLE, IMEM_REQ=0, PC_VALID=0, pending flag cleared, and EPC=0 (when present).
REQ-033 Reset asserted mid-FETCH SHALL abandon the outstanding request without waiting for IMEM_ACK.

Configuration
REQ-034 With macro PC_EXC_EN defined, the EXC and EPC ports SHALL exist.
REQ-035 With PC_EXC_EN defined, EXC in VALID SHALL load EPC with PC and redirect to EXC_VECTOR.
REQ-036 With PC_EXC_EN defined, EXC in FETCH SHALL load EPC with PC and pend a redirect to EXC_VECTOR.
REQ-037 Without PC_EXC_EN, the EXC and EPC ports and all exception logic SHALL be absent, and priority SHALL be JUMP > BRANCH.

Verification
REQ-038 Reset release, IMEM_ACK=1 every cycle, STALL=0 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; PC_VALID high on every other cycle.
REQ-039 PC=0x100 in VALID, STALL=1 for 3 cycles -> PC stays 0x100 with PC_VALID=1 for 3 cycles; STALL=0 -> next fetch at 0x104.
REQ-040 PC=0x20 in FETCH, ACK held low; JUMP with JUMP_TARGET=0x400; ACK arrives 2 cycles later -> no PC_VALID; next fetch at 0x400.
REQ-041 In VALID, JUMP=1 (JUMP_TARGET=0x300) and BRANCH=1 (BRANCH_TARGET=0x200) in the same cycle -> PC=0x300.
REQ-042 PC=0xFFFF_FFFC in VALID, STALL=0 -> PC=0x0000_0000 and PC_PLUS4=0x4.
REQ-043 With PC_EXC_EN, EXC at PC=0x50 in VALID -> EPC=0x50 and PC=0x80; reset asserted mid-FETCH -> IMEM_REQ=0 and PC=RESET_VECTOR on the next cycle.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with IDLE/FETCH/VALID fetch handshake and branch/jump redirects.
// Optional exception redirect and EPC capture are enabled by defining PC_EXC_EN.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STALL,
    input  logic        BRANCH,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        JUMP,
    input  logic [31:0] JUMP_TARGET,
    input  logic        IMEM_ACK,
`ifdef PC_EXC_EN
    input  logic        EXC,
    output logic [31:0] EPC,
`endif
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        PC_VALID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        redir;
    logic [31:0] redir_tgt;
`ifdef PC_EXC_EN
    logic [31:0] epc_q, epc_d;
`endif

    // Redirect selection; exception (when built in) outranks jump, jump outranks branch.
    always_comb begin
        redir     = JUMP | BRANCH;
        redir_tgt = JUMP ? JUMP_TARGET : BRANCH_TARGET;
`ifdef PC_EXC_EN
        if (EXC) begin
            redir     = 1'b1;
            redir_tgt = EXC_VECTOR;
        end
`endif
        redir_tgt = redir_tgt & 32'hFFFF_FFFC;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
`ifdef PC_EXC_EN
        epc_d      = epc_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redir) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt;
`ifdef PC_EXC_EN
                    if (EXC) epc_d = pc_q;
`endif
                end
                // A redirect arriving with the ack still discards the returned fetch.
                if (IMEM_ACK) begin
                    if (pend_d) begin
                        pc_d   = pend_tgt_d;
                        pend_d = 1'b0;
                    end else begin
                        state_d = VALID;
                    end
                end
            end
            VALID: begin
`ifdef PC_EXC_EN
                if (EXC) epc_d = pc_q;
`endif
                if (redir) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end else if (!STALL) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
`ifdef PC_EXC_EN
            epc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
`ifdef PC_EXC_EN
            epc_q      <= epc_d;
`endif
        end
    end

    assign PC        = pc_q;
    assign IMEM_ADDR = pc_q;
    assign PC_PLUS4  = pc_q + 32'd4;
    assign IMEM_REQ  = (state_q == FETCH);
    assign PC_VALID  = (state_q == VALID);
`ifdef PC_EXC_EN
    assign EPC       = epc_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized run against a behavioural model.
// Builds with or without PC_EXC_EN.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset, STALL, BRANCH, JUMP, IMEM_ACK, EXC;
    logic [31:0] BRANCH_TARGET, JUMP_TARGET;
    logic        IMEM_REQ, PC_VALID;
    logic [31:0] IMEM_ADDR, PC, PC_PLUS4;
`ifdef PC_EXC_EN
    logic [31:0] EPC;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase 0=idle, 1=fetching, 2=instruction valid
    int          m_phase;
    logic [31:0] m_pc, m_ptgt, m_epc;
    bit          m_pend;

    always #5 clk = ~clk;

    pc_unit #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clk(clk),
        .reset(reset),
        .STALL(STALL),
        .BRANCH(BRANCH),
        .BRANCH_TARGET(BRANCH_TARGET),
        .JUMP(JUMP),
        .JUMP_TARGET(JUMP_TARGET),
        .IMEM_ACK(IMEM_ACK),
`ifdef PC_EXC_EN
        .EXC(EXC),
        .EPC(EPC),
`endif
        .IMEM_REQ(IMEM_REQ),
        .IMEM_ADDR(IMEM_ADDR),
        .PC(PC),
        .PC_PLUS4(PC_PLUS4),
        .PC_VALID(PC_VALID)
    );

    task automatic model_step();
        bit          e, redirect;
        logic [31:0] tgt;
`ifdef PC_EXC_EN
        e = EXC;
`else
        e = 1'b0;
`endif
        redirect = e | JUMP | BRANCH;
        if (e)         tgt = EV;
        else if (JUMP) tgt = JUMP_TARGET;
        else           tgt = BRANCH_TARGET;
        tgt[1:0] = 2'b00;
        if (reset) begin
            m_phase = 0; m_pc = RV; m_pend = 0; m_epc = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (redirect) begin
                m_pend = 1; m_ptgt = tgt;
                if (e) m_epc = m_pc;
            end
            if (IMEM_ACK) begin
                if (m_pend) begin m_pc = m_ptgt; m_pend = 0; end
                else m_phase = 2;
            end
        end else begin
            if (e) m_epc = m_pc;
            if (redirect) begin m_pc = tgt; m_phase = 1; end
            else if (!STALL) begin m_pc = m_pc + 32'd4; m_phase = 1; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        STALL = 0; BRANCH = 0; JUMP = 0; IMEM_ACK = 0; EXC = 0;
        BRANCH_TARGET = '0; JUMP_TARGET = '0;
    endtask

    // Bring the DUT from reset into VALID with PC at addr (via a jump).
    task automatic go_valid(input logic [31:0] addr);
        quiet();
        reset = 1; tick();
        reset = 0; tick();
        IMEM_ACK = 1; tick();
        IMEM_ACK = 0; JUMP = 1; JUMP_TARGET = addr; tick();
        JUMP = 0; IMEM_ACK = 1; tick();
        quiet();
    endtask

    task automatic test_reset();
        quiet();
        reset = 1; tick(); tick();
        checks++; if (PC !== RV) begin errors++; $display("FAIL reset_pc got=%h exp=%h", PC, RV); end
        checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", IMEM_REQ); end
        checks++; if (PC_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", PC_VALID); end
`ifdef PC_EXC_EN
        checks++; if (EPC !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", EPC); end
`endif
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [5];
        bit          exp_req  [5];
        exp_addr = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        exp_req  = '{1, 0, 1, 0, 1};
        reset = 0; IMEM_ACK = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (IMEM_ADDR !== exp_addr[i]) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, IMEM_ADDR, exp_addr[i]); end
            checks++; if (IMEM_REQ !== exp_req[i]) begin errors++; $display("FAIL seq_req[%0d] got=%b exp=%b", i, IMEM_REQ, exp_req[i]); end
            checks++; if (PC_VALID !== !exp_req[i]) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=%b", i, PC_VALID, !exp_req[i]); end
        end
        quiet();
    endtask

    task automatic test_stall();
        go_valid(32'h100);
        STALL = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PC !== 32'h100 || PC_VALID !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] pc=%h valid=%b exp pc=100 valid=1", i, PC, PC_VALID); end
        end
        STALL = 0; tick();
        checks++; if (IMEM_ADDR !== 32'h104 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL stall_release addr=%h req=%b exp addr=104 req=1", IMEM_ADDR, IMEM_REQ); end
    endtask

    task automatic test_fetch_redirect();
        go_valid(32'h1C);
        tick();
        checks++; if (IMEM_ADDR !== 32'h20 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL fr_start addr=%h req=%b exp addr=20 req=1", IMEM_ADDR, IMEM_REQ); end
        JUMP = 1; JUMP_TARGET = 32'h400; tick();
        JUMP = 0;
        checks++; if (IMEM_ADDR !== 32'h20) begin errors++; $display("FAIL fr_stable1 got=%h exp=20", IMEM_ADDR); end
        tick();
        checks++; if (IMEM_ADDR !== 32'h20 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL fr_stable2 addr=%h req=%b exp addr=20 req=1", IMEM_ADDR, IMEM_REQ); end
        IMEM_ACK = 1; tick();
        IMEM_ACK = 0;
        checks++; if (PC_VALID !== 1'b0 || IMEM_ADDR !== 32'h400 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL fr_discard valid=%b addr=%h req=%b exp valid=0 addr=400 req=1", PC_VALID, IMEM_ADDR, IMEM_REQ); end
        IMEM_ACK = 1; tick();
        IMEM_ACK = 0;
        checks++; if (PC_VALID !== 1'b1 || PC !== 32'h400) begin errors++; $display("FAIL fr_valid valid=%b pc=%h exp valid=1 pc=400", PC_VALID, PC); end
    endtask

    task automatic test_priority();
        go_valid(32'h40);
        JUMP = 1; JUMP_TARGET = 32'h300; BRANCH = 1; BRANCH_TARGET = 32'h200; tick();
        quiet();
        checks++; if (PC !== 32'h300) begin errors++; $display("FAIL prio_jump got=%h exp=300", PC); end
        go_valid(32'h40);
        BRANCH = 1; BRANCH_TARGET = 32'h203; tick();
        quiet();
        checks++; if (PC !== 32'h200 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL branch_align pc=%h req=%b exp pc=200 req=1", PC, IMEM_REQ); end
    endtask

    task automatic test_wrap();
        go_valid(32'hFFFF_FFFC);
        checks++; if (PC_PLUS4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4_pre got=%h exp=0", PC_PLUS4); end
        tick();
        checks++; if (PC !== 32'h0 || PC_PLUS4 !== 32'h4) begin errors++; $display("FAIL wrap pc=%h plus4=%h exp pc=0 plus4=4", PC, PC_PLUS4); end
    endtask

    task automatic test_reset_mid_fetch();
        go_valid(32'h60);
`ifdef PC_EXC_EN
        EXC = 1; JUMP = 1; JUMP_TARGET = 32'h700; tick();
        quiet();
        checks++; if (EPC !== 32'h60 || PC !== EV) begin errors++; $display("FAIL exc_valid epc=%h pc=%h exp epc=60 pc=%h", EPC, PC, EV); end
`else
        tick();
`endif
        checks++; if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL midfetch_req got=%b exp=1", IMEM_REQ); end
        reset = 1; tick();
        reset = 0;
        checks++; if (IMEM_REQ !== 1'b0 || PC !== RV) begin errors++; $display("FAIL midfetch_reset req=%b pc=%h exp req=0 pc=%h", IMEM_REQ, PC, RV); end
    endtask

    task automatic test_random();
        quiet();
        reset = 1; tick();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            STALL         = ($urandom_range(0, 2) == 0);
            IMEM_ACK      = $urandom_range(0, 1);
            JUMP          = ($urandom_range(0, 7) == 0);
            BRANCH        = ($urandom_range(0, 5) == 0);
            JUMP_TARGET   = $urandom;
            BRANCH_TARGET = $urandom;
`ifdef PC_EXC_EN
            EXC           = ($urandom_range(0, 11) == 0);
`endif
            tick();
            checks++; if (PC !== m_pc || IMEM_ADDR !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] pc=%h addr=%h exp=%h", i, PC, IMEM_ADDR, m_pc); end
            checks++; if (PC_PLUS4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d] got=%h exp=%h", i, PC_PLUS4, m_pc + 32'd4); end
            checks++; if (IMEM_REQ !== (m_phase == 1)) begin errors++; $display("FAIL rnd_req[%0d] got=%b exp=%b", i, IMEM_REQ, m_phase == 1); end
            checks++; if (PC_VALID !== (m_phase == 2)) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, PC_VALID, m_phase == 2); end
            checks++; if (PC[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align[%0d] got=%b exp=00", i, PC[1:0]); end
`ifdef PC_EXC_EN
            checks++; if (EPC !== m_epc) begin errors++; $display("FAIL rnd_epc[%0d] got=%h exp=%h", i, EPC, m_epc); end
`endif
        end
        quiet();
        reset = 0;
    endtask

    initial begin
        m_phase = 0; m_pc = RV; m_pend = 0; m_ptgt = 0; m_epc = 0;
        reset = 1;
        quiet();
        test_reset();
        test_sequential();
        test_stall();
        test_fetch_redirect();
        test_priority();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
